// File: rtl/divider_shift_sub_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | divider_shift_sub_if : start/done handshake and operand/result bus for   |
// |                        the shift-subtract divider                        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
interface divider_shift_sub_if #(
    parameter int N = 4
);
    logic             Iniciar;
    logic [2*N-1:0]   Dividendo;
    logic [N-1:0]     Divisor;
    logic [2*N-1:0]   Quociente;
    logic [N-1:0]     Resto;
    logic             Ocupado;
    logic             Pronto;
    logic             ErroDivZero;

    modport master (
        output Iniciar, Dividendo, Divisor,
        input  Quociente, Resto, Ocupado, Pronto, ErroDivZero
    );

    modport slave (
        input  Iniciar, Dividendo, Divisor,
        output Quociente, Resto, Ocupado, Pronto, ErroDivZero
    );
endinterface
`default_nettype wire

// File: rtl/divider_shift_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | divider_shift_sub : sequential restoring divider, 2N/N -> 2N quotient,   |
// |                     N remainder, one shift-subtract step per clock       |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module divider_shift_sub #(
    parameter int N = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    divider_shift_sub_if.slave   bus
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(W + 1);

    localparam logic [1:0] S_OCIOSO  = 2'd0;
    localparam logic [1:0] S_CALCULA = 2'd1;
    localparam logic [1:0] S_FIM     = 2'd2;

    logic [1:0]    state_q,   state_d;
    logic [W-1:0]  work_q,    work_d;
    logic [N-1:0]  divisor_q, divisor_d;
    logic [N:0]    rem_q,     rem_d;
    logic [CW-1:0] count_q,   count_d;
    logic [W-1:0]  quot_q,    quot_d;
    logic [N-1:0]  resto_q,   resto_d;
    logic          erro_q,    erro_d;

    logic [N:0]    w_shifted;
    logic [N+1:0]  w_diff;
    logic          w_trial_ok;
    logic [N:0]    w_rem_next;
    logic [W-1:0]  w_work_next;
    logic          unused_rem_msb;

    // The partial remainder never reaches the divisor, so its top bit stays
    // clear and the shifted value always fits in N+1 bits.
    assign unused_rem_msb = rem_q[N];

    always_comb begin
        w_shifted   = {rem_q[N-1:0], work_q[W-1]};
        w_diff      = {1'b0, w_shifted} - {2'b00, divisor_q};
        w_trial_ok  = ~w_diff[N+1];
        w_rem_next  = w_trial_ok ? w_diff[N:0] : w_shifted;
        // Dividend bits leave at the MSB while quotient bits enter at the LSB.
        w_work_next = {work_q[W-2:0], w_trial_ok};
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        rem_d     = rem_q;
        count_d   = count_q;
        quot_d    = quot_q;
        resto_d   = resto_q;
        erro_d    = erro_q;

        case (state_q)
            S_OCIOSO: begin
                if (bus.Iniciar) begin
                    if (bus.Divisor != '0) begin
                        work_d    = bus.Dividendo;
                        divisor_d = bus.Divisor;
                        rem_d     = '0;
                        count_d   = CW'(W);
                        state_d   = S_CALCULA;
                    end else begin
                        quot_d    = '1;
                        resto_d   = '0;
                        erro_d    = 1'b1;
                        state_d   = S_FIM;
                    end
                end
            end
            S_CALCULA: begin
                work_d  = w_work_next;
                rem_d   = w_rem_next;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    quot_d  = w_work_next;
                    resto_d = w_rem_next[N-1:0];
                    erro_d  = 1'b0;
                    state_d = S_FIM;
                end
            end
            S_FIM: begin
                state_d = S_OCIOSO;
            end
            default: begin
                state_d = S_OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_OCIOSO;
            work_q    <= '0;
            divisor_q <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            quot_q    <= '0;
            resto_q   <= '0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            quot_q    <= quot_d;
            resto_q   <= resto_d;
            erro_q    <= erro_d;
        end
    end

    assign bus.Quociente   = quot_q;
    assign bus.Resto       = resto_q;
    assign bus.ErroDivZero = erro_q;
    assign bus.Ocupado     = (state_q == S_CALCULA);
    assign bus.Pronto      = (state_q == S_FIM);

endmodule
`default_nettype wire

// File: tb/tb_divider_shift_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_divider_shift_sub : directed scoreboard bench for divider_shift_sub   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_divider_shift_sub;
    localparam int N = 4;
    localparam int W = 2 * N;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    divider_shift_sub_if #(.N(N)) bus();

    divider_shift_sub #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [W-1:0] q;
        logic [N-1:0] r;
        logic         e;
    } exp_t;

    exp_t         sb[$];
    int           n_asserts = 0;
    int           n_fail    = 0;
    logic [W-1:0] last_q;
    logic [N-1:0] last_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] dd, input logic [N-1:0] dv);
        exp_t e;
        if (dv == '0) begin
            e.q = '1;
            e.r = '0;
            e.e = 1'b1;
        end else begin
            e.q = dd / W'(dv);
            e.r = N'(dd % W'(dv));
            e.e = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_asserts++;
            n_fail++;
            $error("FAIL %s observed=no_entry expected=scoreboard_entry", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, ".quot"}, 32'(bus.Quociente),   32'(e.q));
        check({tag, ".rem"},  32'(bus.Resto),       32'(e.r));
        check({tag, ".err"},  32'(bus.ErroDivZero), 32'(e.e));
        last_q = e.q;
        last_r = e.r;
    endtask

    // One accepted operation; pulse_at >= 0 injects an extra start request
    // at that cycle of the computation, which the divider must ignore.
    task automatic do_op(input string tag, input logic [W-1:0] dd,
                         input logic [N-1:0] dv, input int pulse_at);
        int k;
        @(negedge clk);
        bus.Iniciar   = 1'b1;
        bus.Dividendo = dd;
        bus.Divisor   = dv;
        push_exp(dd, dv);
        @(negedge clk);
        bus.Iniciar   = 1'b0;
        bus.Dividendo = W'($urandom);
        bus.Divisor   = N'($urandom);
        k = 0;
        while (bus.Pronto !== 1'b1 && k < 40) begin
            check({tag, ".busy"},   32'(bus.Ocupado),   32'd1);
            check({tag, ".hold_q"}, 32'(bus.Quociente), 32'(last_q));
            if (k == pulse_at) begin
                bus.Iniciar   = 1'b1;
                bus.Dividendo = W'(50);
                bus.Divisor   = N'(5);
            end else begin
                bus.Iniciar   = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.Iniciar = 1'b0;
        check({tag, ".pronto_edge"}, 32'(k), (dv == '0) ? 32'd0 : 32'(W));
        check({tag, ".fim_busy"}, 32'(bus.Ocupado), 32'd0);
        pop_check(tag);
        @(negedge clk);
        check({tag, ".pronto_pulse"}, 32'(bus.Pronto),    32'd0);
        check({tag, ".idle_busy"},    32'(bus.Ocupado),   32'd0);
        check({tag, ".hold_after"},   32'(bus.Quociente), 32'(last_q));
        check({tag, ".hold_rem"},     32'(bus.Resto),     32'(last_r));
    endtask

    initial begin
        int  k;
        logic prev_busy;
        logic rise;
        logic seen;

        rst_n         = 1'b0;
        bus.Iniciar   = 1'b0;
        bus.Dividendo = '0;
        bus.Divisor   = '0;
        last_q        = '0;
        last_r        = '0;
        repeat (2) @(negedge clk);
        check("reset.quot",   32'(bus.Quociente),   32'd0);
        check("reset.rem",    32'(bus.Resto),       32'd0);
        check("reset.busy",   32'(bus.Ocupado),     32'd0);
        check("reset.pronto", 32'(bus.Pronto),      32'd0);
        check("reset.err",    32'(bus.ErroDivZero), 32'd0);
        rst_n = 1'b1;

        do_op("200/7",   8'd200, 4'd7,  -1);
        do_op("255/1",   8'd255, 4'd1,  -1);
        do_op("255/15",  8'd255, 4'd15, -1);
        do_op("0/5",     8'd0,   4'd5,  -1);
        do_op("9/15",    8'd9,   4'd15, -1);
        do_op("100/0",   8'd100, 4'd0,  -1);
        do_op("ignore",  8'd200, 4'd7,   3);

        // Start held high: second acceptance lands 2N+2 edges after the first.
        @(negedge clk);
        bus.Iniciar   = 1'b1;
        bus.Dividendo = 8'd45;
        bus.Divisor   = 4'd6;
        push_exp(8'd45, 4'd6);
        push_exp(8'd45, 4'd6);
        k = 0;
        while (bus.Ocupado !== 1'b1 && k < 5) begin
            @(negedge clk);
            k++;
        end
        check("b2b.acc1", 32'(bus.Ocupado), 32'd1);
        k         = 0;
        prev_busy = 1'b1;
        rise      = 1'b0;
        while (!rise && k < 30) begin
            @(negedge clk);
            k++;
            if (bus.Pronto === 1'b1) pop_check("b2b.first");
            if (bus.Ocupado === 1'b1 && prev_busy == 1'b0) rise = 1'b1;
            prev_busy = bus.Ocupado;
        end
        check("b2b.gap", 32'(k), 32'(W + 2));
        bus.Iniciar = 1'b0;
        k = 0;
        while (bus.Pronto !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b.lat2", 32'(k), 32'(W));
        pop_check("b2b.second");
        @(negedge clk);

        // Reset in the middle of a computation aborts it with no Pronto.
        bus.Iniciar   = 1'b1;
        bus.Dividendo = 8'd200;
        bus.Divisor   = 4'd7;
        @(negedge clk);
        bus.Iniciar = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst.quot",   32'(bus.Quociente),   32'd0);
        check("rst.rem",    32'(bus.Resto),       32'd0);
        check("rst.busy",   32'(bus.Ocupado),     32'd0);
        check("rst.pronto", 32'(bus.Pronto),      32'd0);
        check("rst.err",    32'(bus.ErroDivZero), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        last_q = '0;
        last_r = '0;
        seen   = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.Pronto === 1'b1) seen = 1'b1;
        end
        check("rst.no_pronto", 32'(seen), 32'd0);

        do_op("15/15", 8'd15, 4'd15, -1);

        check("sb.drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
